// File: rtl/mips_load_store_unit.sv
// mips_load_store_unit: multi-cycle MIPS load/store unit with a private register file and
// byte-addressed data memory. Supports byte/halfword/word accesses with sign or zero extension.
module mips_load_store_unit #(
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [5:0]                   OpCode,
    input  logic [4:0]                   rs,
    input  logic [4:0]                   rt,
    input  logic [15:0]                  imm,
    output logic                         busy,
    output logic                         done,
    output logic                         fault,
    output logic [31:0]                  eff_addr,
    output logic [31:0]                  xfer_data,
    input  logic [4:0]                   dbg_reg_addr,
    output logic [31:0]                  dbg_reg_data,
    input  logic [$clog2(MEM_DEPTH)-1:0] dbg_mem_addr,
    output logic [31:0]                  dbg_mem_data
);
    localparam int unsigned   AW         = $clog2(MEM_DEPTH);
    localparam int unsigned   CW         = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [31:0]   ADDR_LIMIT = 32'(4 * MEM_DEPTH);
    localparam logic [CW-1:0] CNT_LOAD   = CW'(MEM_LATENCY - 1);

    typedef enum logic [2:0] {StIdle, StAddr, StMem, StDone, StFault} state_t;

    state_t        state_q, state_d;
    logic [5:0]    op_q;
    logic [4:0]    rs_q, rt_q;
    logic [15:0]   imm_q;
    logic [31:0]   eff_addr_q, xfer_q;
    logic [CW-1:0] cnt_q;
    logic          bad_q;
    logic [31:0]   reg_file [32];
    logic [31:0]   mem      [MEM_DEPTH];

    logic          op_valid, is_store, is_unsigned, addr_bad;
    logic [1:0]    size;
    logic [31:0]   addr_sum, rt_val, cur_word, load_val, store_word;
    logic [7:0]    lane_b;
    logic [15:0]   lane_h;
    logic [AW-1:0] word_idx;

    assign word_idx     = eff_addr_q[AW+1:2];
    assign cur_word     = mem[word_idx];
    assign rt_val       = reg_file[rt_q];
    assign addr_sum     = reg_file[rs_q] + {{16{imm_q[15]}}, imm_q};
    assign eff_addr     = eff_addr_q;
    assign xfer_data    = xfer_q;
    assign dbg_reg_data = reg_file[dbg_reg_addr];
    assign dbg_mem_data = mem[dbg_mem_addr];

    // Opcode decode: op[1:0] is the access size, op[2] zero-extend, op[3] store.
    always_comb begin
        op_valid    = op_q inside {6'b100000, 6'b100001, 6'b100011, 6'b100100,
                                   6'b100101, 6'b101000, 6'b101001, 6'b101011};
        size        = op_q[1:0];
        is_unsigned = op_q[2];
        is_store    = op_q[3];
        addr_bad    = !op_valid
                    || (size == 2'b01 && addr_sum[0])
                    || (size == 2'b11 && addr_sum[1:0] != 2'b00)
                    || (addr_sum >= ADDR_LIMIT);
    end

    // Little-endian lane extraction and extension for loads.
    always_comb begin
        lane_b = cur_word[{eff_addr_q[1:0], 3'b000} +: 8];
        lane_h = cur_word[{eff_addr_q[1], 4'b0000} +: 16];
        case (size)
            2'b00:   load_val = is_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
            2'b01:   load_val = is_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
            default: load_val = cur_word;
        endcase
    end

    // Store merge: replace only the addressed lane of the current word.
    always_comb begin
        store_word = cur_word;
        case (size)
            2'b00:   store_word[{eff_addr_q[1:0], 3'b000} +: 8] = rt_val[7:0];
            2'b01:   store_word[{eff_addr_q[1], 4'b0000} +: 16] = rt_val[15:0];
            default: store_word = rt_val;
        endcase
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        fault   = 1'b0;
        case (state_q)
            StIdle:  if (start) state_d = StAddr;
            StAddr: begin
                busy    = 1'b1;
                state_d = StMem;
            end
            StMem: begin
                busy = 1'b1;
                // Address check is taken from the registered result to keep the adder
                // off the compare path; a rejected request leaves after one MEM cycle.
                if (bad_q)              state_d = StFault;
                else if (cnt_q == '0)   state_d = StDone;
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            StFault: begin
                done    = 1'b1;
                fault   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, request latch, address, latency counter and architectural commit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            op_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            imm_q      <= '0;
            eff_addr_q <= '0;
            xfer_q     <= '0;
            cnt_q      <= '0;
            bad_q      <= 1'b0;
            for (int unsigned i = 0; i < 32; i++) reg_file[5'(i)] <= 32'(i);
            for (int unsigned i = 0; i < MEM_DEPTH - 1; i++) mem[AW'(i)] <= 32'(i);
            mem[AW'(MEM_DEPTH - 1)] <= 32'h8081_F0FE;
        end else begin
            state_q <= state_d;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q  <= OpCode;
                        rs_q  <= rs;
                        rt_q  <= rt;
                        imm_q <= imm;
                    end
                end
                StAddr: begin
                    eff_addr_q <= addr_sum;
                    bad_q      <= addr_bad;
                    cnt_q      <= CNT_LOAD;
                end
                StMem: begin
                    if (!bad_q) begin
                        if (cnt_q == '0) begin
                            if (is_store) begin
                                mem[word_idx] <= store_word;
                                xfer_q        <= rt_val;
                            end else begin
                                if (rt_q != 5'd0) reg_file[rt_q] <= load_val;
                                xfer_q <= load_val;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
